// File: rtl/matmul_ctrl.sv
// Sequencer for an N x M output-stationary systolic array computing C = A x B.
// It clears the PEs, feeds K operand steps, flushes the skew, then writes N rows of C.
module matmul_ctrl #(
    parameter int N     = 4,
    parameter int K     = 4,
    parameter int M     = 4,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             hold_i,
    input  logic             ovf_i,
    input  logic             c_ready_i,
    output logic             busy_o,
    output logic             pe_clr_o,
    output logic             op_rd_en_o,
    output logic [IDX_W-1:0] k_idx_o,
    output logic             array_en_o,
    output logic             c_wr_valid_o,
    output logic [IDX_W-1:0] c_row_o,
    output logic             done_o,
    output logic             ovf_o,
    output logic             start_err_o
);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, WRITE, DONE} state_t;

    // Skew drain: the last operand needs N+M-2 extra shifts to reach the far corner PE.
    localparam int               FL     = N + M - 2;
    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(K - 1);
    localparam logic [IDX_W-1:0] N_LAST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] F_LAST = IDX_W'((FL > 0) ? FL - 1 : 0);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] cnt, cnt_nxt;
    logic             ovf_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // Cleared on the accepting edge so ovf_o already reads 0 during CLEAR.
            if (state == IDLE && start_i)
                ovf_q <= 1'b0;
            else if (ovf_i && array_en_o)
                ovf_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pe_clr_o     = 1'b0;
        op_rd_en_o   = 1'b0;
        k_idx_o      = '0;
        array_en_o   = 1'b0;
        c_wr_valid_o = 1'b0;
        c_row_o      = '0;
        done_o       = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (start_i) state_nxt = CLEAR;
            end
            CLEAR: begin
                pe_clr_o  = 1'b1;
                cnt_nxt   = '0;
                state_nxt = FEED;
            end
            FEED: begin
                k_idx_o = cnt;
                if (!hold_i) begin
                    op_rd_en_o = 1'b1;
                    array_en_o = 1'b1;
                    if (cnt == K_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = (FL == 0) ? WRITE : FLUSH;
                    end else begin
                        cnt_nxt = cnt + IDX_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (!hold_i) begin
                    array_en_o = 1'b1;
                    if (cnt == F_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = WRITE;
                    end else begin
                        cnt_nxt = cnt + IDX_W'(1);
                    end
                end
            end
            WRITE: begin
                c_wr_valid_o = 1'b1;
                c_row_o      = cnt;
                if (c_ready_i) begin
                    if (cnt == N_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy_o      = (state != IDLE);
    assign start_err_o = start_i & busy_o;
    assign ovf_o       = ovf_q;

endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 Parameter N, default 4: rows of A and C; number of systolic-array rows.
REQ-002 Parameter K, default 4: columns of A and rows of B; number of feed steps.
REQ-003 Parameter M, default 4: columns of B and C; number of systolic-array columns.
REQ-004 Parameter IDX_W, default 8: width of the k_idx_o and c_row_o indices, and of the internal counters; SHALL be at least clog2(max(K, N, N+M-1)).
REQ-005 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 Port rst_ni, input, 1: asynchronous, active-low reset.
REQ-007 Port start_i, input, 1: request to run one C = A x B operation.
REQ-008 Port hold_i, input, 1: operand stall; freezes the FEED and FLUSH states.
REQ-009 Port ovf_i, input, 1: per-cycle overflow flag from the array.
REQ-010 Port c_ready_i, input, 1: C-memory sink accepts a row write.
REQ-011 Port busy_o, output, 1: high while the state is not IDLE.
REQ-012 Port pe_clr_o, output, 1: clears the accumulators of all processing elements (PEs).
REQ-013 Port op_rd_en_o, output, 1: read enable for column k of A and row k of B.
REQ-014 Port k_idx_o, output, IDX_W: the operand index k.
REQ-015 Port array_en_o, output, 1: shift/MAC enable for the array.
REQ-016 Port c_wr_valid_o, output, 1: row-write request to the C memory.
REQ-017 Port c_row_o, output, IDX_W: the C row being written.
REQ-018 Port done_o, output, 1: one-cycle completion pulse.
REQ-019 Port ovf_o, output, 1: sticky overflow status for the current or last operation.
REQ-020 Port start_err_o, output, 1: one-cycle pulse when start_i is asserted while busy.

Function
REQ-021 The FSM SHALL have the states IDLE, CLEAR, FEED, FLUSH, WRITE and DONE; state and counters are registered, and outputs are decoded from them.
REQ-022 IDLE: when start_i=1 at an edge, next state is CLEAR; otherwise stay in IDLE.
REQ-023 CLEAR lasts one cycle with pe_clr_o=1; it clears ovf_o and the counters; next state is FEED.
REQ-024 FEED:
- op_rd_en_o=1, array_en_o=1 and k_idx_o=k, for k=0..K-1, while hold_i=0.
- With hold_i=1: op_rd_en_o=0, array_en_o=0, and k is frozen.
- Next state is FLUSH after k=K-1 is issued; go directly to WRITE if N+M-2=0.
REQ-025 FLUSH:
- array_en_o=1 and op_rd_en_o=0 for N+M-2 non-held cycles; the datapath feeds zeros.
- hold_i freezes the counter and drops array_en_o.
- Next state is WRITE.
REQ-026 WRITE:
- c_wr_valid_o=1 and c_row_o=r, for r=0..N-1.
- r advances only on a cycle where c_wr_valid_o=1 and c_ready_i=1.
- c_row_o stays stable while c_ready_i=0.
- Next state is DONE after row N-1 is accepted.
REQ-027 DONE lasts one cycle with done_o=1; next state is IDLE.
REQ-028 hold_i SHALL be ignored in IDLE, CLEAR, WRITE and DONE.
REQ-029 ovf_o SHALL be set on any cycle with ovf_i=1 and array_en_o=1, and hold until the next CLEAR.
REQ-030 start_err_o SHALL pulse for one cycle when start_i=1 and busy_o=1; the running operation is unaffected.
REQ-031 start_i=1 in the DONE cycle SHALL be flagged by start_err_o; a new start is accepted only from IDLE.
REQ-032 Back-to-back operation: start_i held high SHALL restart from IDLE on the cycle after DONE.
REQ-033 Latency with hold_i=0 and c_ready_i=1: done_o SHALL assert exactly 1+K+(N+M-2)+N cycles after the start-sampling edge.
REQ-034 All counters SHALL compare against parameter-derived terminal values only; there is no wrap-around past a terminal value.

Reset
REQ-035 When rst_ni=0, asynchronously:
- state = IDLE;
- all counters = 0;
- busy_o, pe_clr_o, op_rd_en_o, array_en_o, c_wr_valid_o, done_o, ovf_o and start_err_o = 0;
- k_idx_o and c_row_o = 0.
REQ-036 Reset asserted in any state SHALL abort the operation with no done_o.
REQ-037 After reset releases, the FSM remains in IDLE until start_i is asserted.

Verification
REQ-038 Nominal run, N=K=M=4, start pulse at cycle 0:
- pe_clr_o at cycle 1;
- k_idx_o = 0..3 at cycles 2-5;
- FLUSH at cycles 6-11;
- c_row_o = 0..3 at cycles 12-15;
- done_o at cycle 16 and never at any other cycle.
REQ-039 Hold during FEED: hold_i=1 for 3 cycles while k=2:
- k_idx_o stays at 2;
- op_rd_en_o=0 and array_en_o=0 during the hold;
- done_o at cycle 19.
REQ-040 Write backpressure: c_ready_i=0 for 2 cycles at row 1:
- c_row_o=1 held stable with c_wr_valid_o=1;
- done_o delayed by 2 cycles;
- exactly 4 accepted writes.
REQ-041 Start while busy, start_i=1 at cycle 7:
- start_err_o pulses at cycle 7;
- done_o still at cycle 16, with no second run.
REQ-042 Overflow: ovf_i=1 in a FLUSH cycle:
- ovf_o=1 until the next CLEAR;
- ovf_o returns to 0 in the CLEAR cycle of the next run.
REQ-043 Reset mid-run: rst_ni=0 asserted during WRITE:
- all outputs 0 immediately (asynchronously);
- no done_o;
- a new start after release gives the nominal REQ-038 timing.
